// File: rtl/pixel_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// pixel_buffer : elastic FIFO from shader pixel writes to the frame-buffer writer
// Optional macro PB_FRAME_DONE_EN adds an end-of-frame pop counter.  Rev 1.0
// =============================================================================
module pixel_buffer #(
  parameter int  DEPTH       = 16,
  parameter int  FULL_MARGIN = 2,
  parameter int  NUM_PIXELS  = 307200,
  parameter type pixel_buffer_entry_t = logic [42:0]
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pb_we,
  input  pixel_buffer_entry_t pb_data_out,
  output logic                pb_full,
  output logic                pb_to_fb_valid,
  output pixel_buffer_entry_t pb_to_fb_data,
  input  logic                pb_to_fb_stall,
  output logic                pb_overflow,
  output logic                frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH - FULL_MARGIN);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || FULL_MARGIN < 0 ||
      FULL_MARGIN >= DEPTH || NUM_PIXELS < 1) begin : g_param_check
    $error("pixel_buffer: illegal parameter combination");
  end

  pixel_buffer_entry_t mem_q [DEPTH];
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                push, pop, drop;

  // A write into a full buffer is dropped even when the head pops this cycle,
  // so the accept decision depends only on the registered occupancy.
  always_comb begin
    push       = pb_we && (count_q != DEPTH_CNT);
    drop       = pb_we && (count_q == DEPTH_CNT);
    pop        = (count_q != '0) && !pb_to_fb_stall;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    overflow_d = overflow_q | drop;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: an entry is only observed once count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pb_data_out;
    end
  end

  assign pb_to_fb_valid = (count_q != '0);
  assign pb_to_fb_data  = mem_q[rd_ptr_q];
  assign pb_full        = (count_q >= FULL_LVL);
  assign pb_overflow    = overflow_q;

`ifdef PB_FRAME_DONE_EN
  localparam int FW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [FW-1:0] LAST_PIX = FW'(NUM_PIXELS - 1);

  logic [FW-1:0] pix_cnt_q, pix_cnt_d;
  logic          frame_done_q, frame_done_d;

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    if (pop) begin
      if (pix_cnt_q == LAST_PIX) begin
        pix_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;
`else
  assign frame_done = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/pixel_buffer.md
# pixel_buffer

Elastic buffer that receives finished-pixel writes from `simple_shader_unit` on the `pb_we` / `pb_data_out` / `pb_full` interface. It drains them in order to the frame-buffer writer through a valid/stall handshake. It absorbs shader bursts and back-pressures the shader early enough to cover writes already in flight in the shader pipeline.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; must be a power of two, at least 4.
- `FULL_MARGIN`, 2: free slots still remaining when `pb_full` asserts; must be less than `DEPTH`.
- `NUM_PIXELS`, 307200: pixels per frame; used only with `PB_FRAME_DONE_EN`.

Ports:
- `clk`, in, 1: single clock; all state is updated on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `pb_we`, in, 1: shader write strobe.
- `pb_data_out`, in, `pixel_buffer_entry_t`: pixelID and color from the shader.
- `pb_full`, out, 1: back-pressure to the shader.
- `pb_to_fb_valid`, out, 1: head entry is valid.
- `pb_to_fb_data`, out, `pixel_buffer_entry_t`: head entry.
- `pb_to_fb_stall`, in, 1: downstream cannot accept this cycle.
- `pb_overflow`, out, 1: sticky error, set when a write is dropped.
- `frame_done`, out, 1: one-cycle pulse at end of frame.

## Operation
- Storage is a circular buffer of `DEPTH` flop entries with read pointer `rd_ptr`, write pointer `wr_ptr` and occupancy `count`. `count` is log2(`DEPTH`)+1 bits.
- Push:
  - `pb_we` is high and `count < DEPTH`, where `count` is the value at the start of the cycle.
  - Entry is written at `wr_ptr`, then `wr_ptr` increments and wraps modulo `DEPTH`.
- Dropped write:
  - `pb_we` is high and `count == DEPTH`.
  - The write is dropped even if a pop occurs in the same cycle.
  - `pb_overflow` is set and stays set until `rst`.
- Pop:
  - `pb_to_fb_valid` is high and `pb_to_fb_stall` is low.
  - `rd_ptr` increments and wraps modulo `DEPTH`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Output is show-ahead:
  - `pb_to_fb_valid = (count != 0)`.
  - `pb_to_fb_data = mem[rd_ptr]`.
  - Head data is held stable while stalled.
- `pb_full = (count >= DEPTH - FULL_MARGIN)`. It is derived only from registered `count`, with no combinational path from `pb_we`.
- Entries leave in exactly the order they were accepted; pixelID is never reordered or modified.
- `pb_data_out` is ignored when `pb_we` is low. X on it must not propagate into stored state.

## Timing
- Reset values:
  - `count`, `rd_ptr`, `wr_ptr` are 0.
  - `pb_to_fb_valid`, `pb_full`, `pb_overflow`, `frame_done` are 0.
  - `pb_to_fb_data` is don't-care.
- Latency: a write at edge N makes `pb_to_fb_valid` high after edge N, so data is poppable in cycle N+1.
- Throughput: one push and one pop per cycle are sustained indefinitely.
- `pb_full` updates the cycle after the push that crosses the threshold. The shader may issue up to `FULL_MARGIN` further writes without loss.
- Reset asserted mid-burst:
  - Contents are discarded immediately and all outputs go to their reset values asynchronously.
  - The first write after `rst` falls lands at index 0.

## Configuration
- Macro: `PB_FRAME_DONE_EN`.
- When defined:
  - A pop counter of width ceil(log2(`NUM_PIXELS`)) counts popped entries.
  - On the pop that brings the count to `NUM_PIXELS`, the counter resets to 0 and `frame_done` pulses high for exactly the following cycle.
  - `rst` clears the counter.
- When undefined: `frame_done` is tied to 0, no counter is instantiated, and `NUM_PIXELS` is unused.

## Test plan
All scenarios use `DEPTH`=8, `FULL_MARGIN`=2.
- Single write:
  - Stimulus: `pb_we` for one cycle with pixelID 'h9, color 'h123456; `pb_to_fb_stall` held 0.
  - Response: `pb_to_fb_valid` is high for exactly one cycle, one cycle later, carrying 'h9 / 'h123456.
  - Response: `count` returns to 0.
- Fill under stall:
  - Stimulus: `pb_to_fb_stall`=1 while writing pixelIDs 0 through 9 on consecutive cycles.
  - Response: `pb_full` rises after the 6th push.
  - Response: pushes 0–7 are accepted; pushes 8 and 9 are dropped and `pb_overflow`=1.
  - Stimulus: release the stall.
  - Response: pixelIDs 0–7 come out in order, back-to-back.
- Full with simultaneous push and pop:
  - Stimulus: with `count`=8 and stall low, `pb_we` pixelID 'h20.
  - Response: the head pops, the write is dropped, `count`=7, and `pb_overflow`=1.
- Wrap-around:
  - Stimulus: 40 writes streamed with a random stall at 50%.
  - Response: all 40 pixelIDs exit in order.
  - Response: `pb_overflow` stays 0 when the writer obeys `pb_full`.
- Reset mid-operation:
  - Stimulus: assert `rst` with `count`=5.
  - Response: outputs clear without waiting for a clock edge.
  - Stimulus: a subsequent write of pixelID 'h3.
  - Response: 'h3 is the only entry seen downstream.
- With `PB_FRAME_DONE_EN` and `NUM_PIXELS`=12:
  - Stimulus: stream 24 pixels.
  - Response: `frame_done` pulses exactly twice, in the cycle after the 12th pop and the cycle after the 24th pop.
- Without `PB_FRAME_DONE_EN`:
  - Stimulus: the same 24-pixel stream.
  - Response: `frame_done` stays 0.
